iop_bus_bridge: RTL
===================

IOP_BUS_BRIDGE -- requirements
Module: iop_bus_bridge

Interface
REQ-001 Parameters SHALL be (name, default, meaning):
- AW, 21, address width.
- DW, 8, data width.
- WBUF_DEPTH, 4, posted-write buffer entries; power of two, at least 2.

REQ-002 Ports SHALL be (name, direction, width, meaning):
- sysclk, in, 1, sole clock; all state on its rising edge.
- sysrst, in, 1, synchronous active-high reset.
- core_addr, in, AW, core access address.
- core_wdata, in, DW, core write data.
- core_write, in, 1, core write request.
- core_read, in, 1, core read request; core holds it until core_rdy.
- core_rdata, out, DW, registered read data.
- core_rdy, out, 1, current core access accepted or completed this cycle.
- IOPWADDR, out, AW, write address to memory side.
- IOPWDATA, out, DW, write data to memory side.
- IOPWREQ, out, 1, write request to memory side.
- IOPWWAIT, in, 1, memory-side write stall.
- IOPRADDR, out, AW, read address to memory side.
- IOPRREQ, out, 1, read request to memory side.
- IOPRDATA, in, DW, memory-side read data.
- IOPRWAIT, in, 1, memory-side read stall.
- wbuf_level, out, clog2(WBUF_DEPTH)+1, number of write-buffer entries occupied.

REQ-003 The block SHALL have a single clock domain (sysclk); reset sysrst SHALL be synchronous and active-high.

Function
REQ-004 Writes SHALL be posted into a WBUF_DEPTH-entry FIFO holding {addr, wdata}.
REQ-005 A core write SHALL be accepted when core_write=1 and wbuf_level<WBUF_DEPTH; core_rdy SHALL be 1 combinationally in that cycle and the entry SHALL be pushed at that edge.
REQ-006 When the buffer is full, core_rdy SHALL be 0 for a write, even if a pop occurs in the same cycle; the write is accepted in the next cycle.
REQ-007 While the buffer is non-empty, IOPWREQ SHALL be 1 and IOPWADDR/IOPWDATA SHALL present the head entry; otherwise IOPWREQ=0 and IOPWADDR/IOPWDATA=0.
REQ-008 The head entry SHALL pop at the edge where IOPWREQ=1 and IOPWWAIT=0.
REQ-009 On a simultaneous push and pop, wbuf_level SHALL be unchanged. FIFO pointers SHALL wrap modulo WBUF_DEPTH. Write ordering SHALL be strictly FIFO.
REQ-010 The read FSM SHALL have states IDLE, DRAIN, RREQ, RDONE.
REQ-011 IDLE: on core_read=1 and core_write=0, the FSM SHALL latch core_addr and go to DRAIN if wbuf_level!=0, else to RREQ.
REQ-012 DRAIN: the FSM SHALL stay until wbuf_level=0, then go to RREQ (read-after-write ordering).
REQ-013 RREQ: IOPRREQ SHALL be 1 and IOPRADDR SHALL be the latched address. When IOPRWAIT=0, core_rdata SHALL capture IOPRDATA and the FSM SHALL go to RDONE.
REQ-014 RDONE: core_rdy SHALL be 1 for exactly one cycle, then the FSM SHALL return to IDLE.
REQ-015 IOPRREQ=0 and IOPRADDR=0 in all states other than RREQ.
REQ-016 Read latency with an empty buffer and no wait SHALL be: core_rdy asserted 2 cycles after the first core_read cycle.
REQ-017 core_rdata SHALL hold its value until the next read capture.
REQ-018 core_write=1 and core_read=1 together in IDLE: the write SHALL be serviced per REQ-005 and the read SHALL not start that cycle.
REQ-019 core_write asserted while the FSM is not IDLE SHALL be ignored, with core_rdy=0 except in RDONE.
REQ-020 With neither core_read nor core_write asserted, core_rdy SHALL be 0.

Reset
REQ-021 While sysrst=1 at an edge:
- the FIFO SHALL be emptied (wbuf_level=0) and the FSM SHALL go to IDLE;
- core_rdata SHALL be 0;
- IOPWREQ, IOPRREQ and core_rdy SHALL be 0 from the following cycle.
REQ-022 Reset mid-operation SHALL discard buffered writes and any in-flight read without completing them. No memory-side request SHALL be asserted in the cycle after reset.

Verification
REQ-023 Push 0x11@0x00010, then 0x22@0x00020, with IOPWWAIT=0 -> core_rdy=1 on each write; IOPWREQ presents 0x00010/0x11 then 0x00020/0x22 in order; wbuf_level returns to 0.
REQ-024 IOPWWAIT=1 with 5 back-to-back writes at DEPTH 4 -> first 4 accepted, wbuf_level=4, 5th write core_rdy=0; release IOPWWAIT -> 5th write accepted in the cycle after the first pop.
REQ-025 Read 0x1FFFFF with empty buffer, IOPRWAIT=0, IOPRDATA=0xA5 -> IOPRREQ one cycle with IOPRADDR=0x1FFFFF; core_rdy 2 cycles after the read starts; core_rdata=0xA5.
REQ-026 Write 0x5A@0x100, then read 0x100 while IOPWWAIT=1 for 3 cycles -> IOPRREQ stays 0 until the write pops; the read is then issued and completes.
REQ-027 Read with IOPRWAIT=1 for 4 cycles -> IOPRREQ held 5 cycles; core_rdy pulses once; core_rdata unchanged until the capture.
REQ-028 Fill the buffer with 3 entries, start a read, assert sysrst for 1 cycle -> wbuf_level=0, IOPWREQ=0, IOPRREQ=0, core_rdata=0, FSM in IDLE.

Source files
------------

// File: rtl/iop_bus_bridge.sv
// iop_bus_bridge
// ------------------------------------------------------------------------
// Bridges a simple core bus onto a split read/write memory-side port.
// Core writes are posted into a small FIFO and drained to the memory side in
// order. Core reads are handled by a small FSM. It first waits for the write
// buffer to empty, so a read can never overtake an earlier write. It then
// issues a single read request and completes the core access one cycle after
// the data is captured.
//
// Handshake semantics:
//   core side  : a write completes in the cycle where core_write=1 and
//                core_rdy=1. A read is held by the core until core_rdy=1.
//                core_rdata is valid in that cycle and holds until the next
//                read capture.
//   memory side: IOPWREQ/IOPRREQ act as "valid", and IOPWWAIT/IOPRWAIT act
//                as an inverted "ready". A request transfers at the edge
//                where REQ=1 and WAIT=0. The request and its address/data
//                stay stable while WAIT=1.
//
// Ports
//   sysclk, sysrst            clock, synchronous active-high reset
//   core_addr/wdata           core access address / write data
//   core_write, core_read     core access requests
//   core_rdata, core_rdy      registered read data, access accepted/completed
//   IOPWADDR/WDATA/WREQ       memory-side write request (head of buffer)
//   IOPWWAIT                  memory-side write stall
//   IOPRADDR/RREQ             memory-side read request
//   IOPRDATA, IOPRWAIT        memory-side read data and read stall
//   wbuf_level                occupied write-buffer entries
// ------------------------------------------------------------------------
module iop_bus_bridge #(
    parameter int AW         = 21,
    parameter int DW         = 8,
    parameter int WBUF_DEPTH = 4
) (
    input  logic                          sysclk,
    input  logic                          sysrst,
    input  logic [AW-1:0]                 core_addr,
    input  logic [DW-1:0]                 core_wdata,
    input  logic                          core_write,
    input  logic                          core_read,
    output logic [DW-1:0]                 core_rdata,
    output logic                          core_rdy,
    output logic [AW-1:0]                 IOPWADDR,
    output logic [DW-1:0]                 IOPWDATA,
    output logic                          IOPWREQ,
    input  logic                          IOPWWAIT,
    output logic [AW-1:0]                 IOPRADDR,
    output logic                          IOPRREQ,
    input  logic [DW-1:0]                 IOPRDATA,
    input  logic                          IOPRWAIT,
    output logic [$clog2(WBUF_DEPTH):0]   wbuf_level
);

    localparam int PW = $clog2(WBUF_DEPTH);
    localparam int LW = PW + 1;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        DRAIN = 2'd1,
        RREQ  = 2'd2,
        RDONE = 2'd3
    } rd_state_e;

    rd_state_e       state_q, state_d;
    logic [AW-1:0]   raddr_q, raddr_d;
    logic [DW-1:0]   rdata_q, rdata_d;

    // Write buffer storage. It has no reset because the pointers define validity.
    logic [AW-1:0]   wbuf_addr [WBUF_DEPTH];
    logic [DW-1:0]   wbuf_data [WBUF_DEPTH];
    logic [PW-1:0]   wr_ptr_q, wr_ptr_d;
    logic [PW-1:0]   rd_ptr_q, rd_ptr_d;
    logic [LW-1:0]   count_q, count_d;

    logic            wbuf_empty;
    logic            wbuf_full;
    logic            wbuf_push;
    logic            wbuf_pop;

    assign wbuf_empty = (count_q == '0);
    // Fullness uses the registered count only. A pop in the same cycle does not
    // free a slot until the next cycle, which keeps core_rdy off the WAIT path.
    assign wbuf_full  = (count_q == LW'(WBUF_DEPTH));
    assign wbuf_pop   = !wbuf_empty && !IOPWWAIT;

    // ------------------------------------------------------------------
    // Read FSM and core handshake
    // ------------------------------------------------------------------
    always_comb begin
        state_d   = state_q;
        raddr_d   = raddr_q;
        rdata_d   = rdata_q;
        wbuf_push = 1'b0;
        core_rdy  = 1'b0;
        IOPRREQ   = 1'b0;
        IOPRADDR  = '0;
        unique case (state_q)
            IDLE: begin
                // Writes are only serviced here. When write and read arrive
                // together, the write wins and the read waits.
                wbuf_push = core_write && !wbuf_full;
                core_rdy  = wbuf_push;
                if (core_read && !core_write) begin
                    raddr_d = core_addr;
                    state_d = wbuf_empty ? RREQ : DRAIN;
                end
            end
            DRAIN: begin
                // No pushes happen outside IDLE, so the level only falls here.
                if (wbuf_empty) begin
                    state_d = RREQ;
                end
            end
            RREQ: begin
                IOPRREQ  = 1'b1;
                IOPRADDR = raddr_q;
                if (!IOPRWAIT) begin
                    rdata_d = IOPRDATA;
                    state_d = RDONE;
                end
            end
            RDONE: begin
                core_rdy = 1'b1;
                state_d  = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge sysclk) begin
        if (sysrst) begin
            state_q <= IDLE;
            raddr_q <= '0;
            rdata_q <= '0;
        end else begin
            state_q <= state_d;
            raddr_q <= raddr_d;
            rdata_q <= rdata_d;
        end
    end

    // ------------------------------------------------------------------
    // Posted-write FIFO
    // ------------------------------------------------------------------
    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        // Pointers are PW bits wide, so incrementing them wraps modulo the depth.
        if (wbuf_push) begin
            wr_ptr_d = wr_ptr_q + PW'(1);
        end
        if (wbuf_pop) begin
            rd_ptr_d = rd_ptr_q + PW'(1);
        end
        unique case ({wbuf_push, wbuf_pop})
            2'b10:   count_d = count_q + LW'(1);
            2'b01:   count_d = count_q - LW'(1);
            default: count_d = count_q;
        endcase
    end

    always_ff @(posedge sysclk) begin
        if (sysrst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    always_ff @(posedge sysclk) begin
        if (wbuf_push) begin
            wbuf_addr[wr_ptr_q] <= core_addr;
            wbuf_data[wr_ptr_q] <= core_wdata;
        end
    end

    // ------------------------------------------------------------------
    // Outputs
    // ------------------------------------------------------------------
    assign IOPWREQ    = !wbuf_empty;
    assign IOPWADDR   = wbuf_empty ? '0 : wbuf_addr[rd_ptr_q];
    assign IOPWDATA   = wbuf_empty ? '0 : wbuf_data[rd_ptr_q];
    assign wbuf_level = count_q;
    assign core_rdata = rdata_q;

endmodule
